serial_row_loader: RTL and testbench
====================================

// Module: serial_row_loader
// PURPOSE
// Front-end of the SGD datapath: deserialises the LSB-first serial training stream on S into
// full data-point rows and writes each row into the row memory consumed by the SGD core.
// One row = feat+1 16-bit words (features plus y). Raises load_done once rows 0..data_points are stored.
// PARAMETERS
// ADDR_WIDTH    12    width of row address and data_points
// MAX_FEATURES  15    largest supported feat value
// LENGTH        16    bits per word
// DATA_WIDTH    LENGTH*(MAX_FEATURES+1)    row width written to memory
// PORTS
// CLK          in   1           clock; all sampling is on the rising edge
// RST          in   1           asynchronous reset, active-low
// S            in   1           serial data; one bit per CLK while loading
// feat         in   4           highest word index per row; row holds feat+1 words
// data_points  in   ADDR_WIDTH  last row index; data_points+1 rows are loaded
// wr_en        out  1           one-cycle row-write strobe
// wr_addr      out  ADDR_WIDTH  row index for the write
// wr_data      out  DATA_WIDTH  assembled row; word j in [LENGTH*j +: LENGTH]
// busy         out  1           high while in LOAD
// load_done    out  1           sticky completion flag for the SGD core
// BEHAVIOUR
// - Reset (RST=0): all outputs 0, all counters 0, state LOAD_ARM. Reset is honoured mid-row/mid-load:
//   the partial row is discarded, no write occurs, memory contents are left as-is.
// - FSM: LOAD_ARM -> LOAD -> DONE. DONE is left only via reset.
// - LOAD_ARM: lasts until the first rising edge after reset release. That edge latches feat and
//   data_points, captures bit 0 of the first word and enters LOAD. busy=1 from that edge.
//   The latched values are held for the whole load. Later changes to the inputs are ignored.
// - feat > MAX_FEATURES is clamped to MAX_FEATURES at latch time.
// - Bit order: within a word, the LSB arrives first.
//   Word order within a row: index feat first, down to index 0.
//   Rows arrive in order 0..data_points.
// - Counters:
//   - bit_cnt 0..LENGTH-1.
//   - word_idx counts from feat down to 0.
//   - row_cnt counts 0..data_points.
//   - Every counter wraps or reloads on the edge that captures its last bit, so there are no idle cycles between words or rows.
// - Row assembly: the shift register fills word slot word_idx. Slots above the latched feat are forced to 0.
// - Write timing: on the edge that captures the final bit of word 0:
//   - wr_en<=1, wr_addr<=row_cnt, and wr_data<=the complete row including that bit.
//   - wr_en is high for exactly one cycle, which gives 1-cycle latency after the last bit.
//   - wr_data/wr_addr hold their values until the next write.
// - Completion: the edge that writes row data_points also sets load_done=1 and busy=0, and moves to DONE.
//   - wr_en is high in the first DONE cycle (final strobe).
//   - In DONE, S is ignored, there are no further writes, and load_done stays 1.
// - Total load = (data_points+1)*(feat+1)*LENGTH edges.
// - Edge cases:
//   - feat=0 gives 1-word rows.
//   - data_points=0 gives a single row.
//   - row_cnt never exceeds data_points, so addresses do not wrap.
// CONFIGURATION
// - LOADER_CSUM_EN defined: adds output csum[15:0].
//   - csum is a wrap-around 16-bit sum of every received word.
//   - It is cleared at reset and updated on each word-completing edge.
//   - It is frozen in DONE and is valid when load_done rises.
// - LOADER_CSUM_EN undefined: no csum port and no adder logic. All other behaviour is identical.
// TESTING
// - T1: feat=1, dp=0; stream 0xABCD (j=1) then 0x1234 (j=0)
//   -> one wr_en, wr_addr=0, wr_data[31:0]=0xABCD1234, upper bits 0;
//   load_done=1 on that same edge; 32 edges total.
// - T2: feat=11, dp=6, 7 rows of known words
//   -> 7 single-cycle wr_en at addr 0..6, exactly 192 edges apart;
//   each wr_data matches the source row; load_done after 1344 edges.
// - T3: feat=15 (max), dp=2
//   -> every row fills all 256 bits; feat=15 is not clamped;
//   drive feat=4'hF with MAX_FEATURES=8 -> rows hold 9 words and the rest are 0.
// - T4: assert RST low mid-word of row 3 of 5, then release
//   -> outputs clear asynchronously and no write for row 3;
//   reload from row 0 writes addr 0 first.
// - T5: keep toggling S for 100 cycles after load_done, and change feat/data_points mid-load
//   -> no extra wr_en; row geometry unchanged.
// - T6 (LOADER_CSUM_EN): words 0xFFFF, 0x0002
//   -> csum=0x0001 at load_done; rebuild without the macro and the T1 results are identical.

Source files
------------

// File: rtl/serial_row_loader.sv
// Deserialises an LSB-first serial stream into feat+1-word rows and writes each row to row memory.
// Optional: define LOADER_CSUM_EN to add a 16-bit wrap-around checksum of all received words.
module serial_row_loader #(
   parameter int ADDR_WIDTH   = 12,
   parameter int MAX_FEATURES = 15,
   parameter int LENGTH       = 16,
   parameter int DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  S,
   input  logic [3:0]            feat,
   input  logic [ADDR_WIDTH-1:0] data_points,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  busy,
   output logic                  load_done
`ifdef LOADER_CSUM_EN
   ,
   output logic [15:0]           csum
`endif
);

   typedef enum logic [1:0] {LOAD_ARM, LOAD, DONE} state_e;

   localparam int                BW       = $clog2(LENGTH);
   localparam logic [BW-1:0]     LAST_BIT = BW'(LENGTH - 1);
   localparam logic [3:0]        MAX_F    = 4'(MAX_FEATURES);

   state_e                  state_q,    state_d;
   logic [3:0]              feat_q,     feat_d;
   logic [ADDR_WIDTH-1:0]   dp_q,       dp_d;
   logic [BW-1:0]           bit_cnt_q,  bit_cnt_d;
   logic [3:0]              word_idx_q, word_idx_d;
   logic [ADDR_WIDTH-1:0]   row_cnt_q,  row_cnt_d;
   logic [LENGTH-1:0]       shift_q,    shift_d;
   logic [DATA_WIDTH-1:0]   row_q,      row_d;
   logic                    wr_en_q,    wr_en_d;
   logic [ADDR_WIDTH-1:0]   wr_addr_q,  wr_addr_d;
   logic [DATA_WIDTH-1:0]   wr_data_q,  wr_data_d;
   logic                    busy_q,     busy_d;
   logic                    done_q,     done_d;
`ifdef LOADER_CSUM_EN
   logic [15:0]             csum_q,     csum_d;
`endif

   // Position of the bit captured on this edge; the arming edge is bit 0 of the first word.
   logic [3:0]              cur_word;
   logic [BW-1:0]           cur_bit;
   logic [ADDR_WIDTH-1:0]   cur_row;

   always_comb begin
      // NOTE: every signal gets a default first so no path through this block infers a latch.
      state_d    = state_q;
      feat_d     = feat_q;
      dp_d       = dp_q;
      bit_cnt_d  = bit_cnt_q;
      word_idx_d = word_idx_q;
      row_cnt_d  = row_cnt_q;
      shift_d    = shift_q;
      row_d      = row_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      busy_d     = busy_q;
      done_d     = done_q;
`ifdef LOADER_CSUM_EN
      csum_d     = csum_q;
`endif
      cur_word   = word_idx_q;
      cur_bit    = bit_cnt_q;
      cur_row    = row_cnt_q;

      if (state_q == LOAD_ARM) begin
         feat_d   = (feat > MAX_F) ? MAX_F : feat;
         dp_d     = data_points;
         cur_word = feat_d;
         cur_bit  = '0;
         cur_row  = '0;
         busy_d   = 1'b1;
         state_d  = LOAD;
      end

      if (state_q != DONE) begin
         shift_d    = {S, shift_q[LENGTH-1:1]};
         word_idx_d = cur_word;
         row_cnt_d  = cur_row;
         if (cur_bit == LAST_BIT) begin
            bit_cnt_d                         = '0;
            row_d[LENGTH*cur_word +: LENGTH]  = shift_d;
`ifdef LOADER_CSUM_EN
            csum_d = csum_q + 16'(shift_d);
`endif
            if (cur_word == 4'd0) begin
               wr_en_d   = 1'b1;
               wr_addr_d = cur_row;
               // Slots above the latched feature count never carry data.
               for (int j = 0; j <= MAX_FEATURES; j++)
                  wr_data_d[LENGTH*j +: LENGTH] = (4'(j) <= feat_d) ? row_d[LENGTH*j +: LENGTH] : '0;
               if (cur_row == dp_d) begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  row_cnt_d  = cur_row + ADDR_WIDTH'(1);
                  word_idx_d = feat_d;
               end
            end else begin
               word_idx_d = cur_word - 4'd1;
            end
         end else begin
            bit_cnt_d = cur_bit + BW'(1);
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= LOAD_ARM;
         feat_q     <= '0;
         dp_q       <= '0;
         bit_cnt_q  <= '0;
         word_idx_q <= '0;
         row_cnt_q  <= '0;
         shift_q    <= '0;
         row_q      <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef LOADER_CSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         feat_q     <= feat_d;
         dp_q       <= dp_d;
         bit_cnt_q  <= bit_cnt_d;
         word_idx_q <= word_idx_d;
         row_cnt_q  <= row_cnt_d;
         shift_q    <= shift_d;
         row_q      <= row_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef LOADER_CSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign busy      = busy_q;
   assign load_done = done_q;
`ifdef LOADER_CSUM_EN
   assign csum      = csum_q;
`endif

endmodule

// File: tb/tb_serial_row_loader.sv
// Bench for serial_row_loader: two instances (MAX_FEATURES 15 and 8) fed one stream,
// checked every cycle against a bit-stream row model plus hand-computed literals.
module tb_serial_row_loader;

   logic         CLK;
   logic         RST;
   logic         S;
   logic [3:0]   feat;
   logic [11:0]  data_points;

   logic         we1, bz1, ld1, we2, bz2, ld2;
   logic [11:0]  wa1, wa2;
   logic [255:0] wd1;
   logic [143:0] wd2;
`ifdef LOADER_CSUM_EN
   logic [15:0]  cs1, cs2;
`endif

   serial_row_loader #(.MAX_FEATURES(15)) dut15 (
      .CLK(CLK), .RST(RST), .S(S), .feat(feat), .data_points(data_points),
      .wr_en(we1), .wr_addr(wa1), .wr_data(wd1), .busy(bz1), .load_done(ld1)
`ifdef LOADER_CSUM_EN
      , .csum(cs1)
`endif
   );

   serial_row_loader #(.MAX_FEATURES(8)) dut8 (
      .CLK(CLK), .RST(RST), .S(S), .feat(feat), .data_points(data_points),
      .wr_en(we2), .wr_addr(wa2), .wr_data(wd2), .busy(bz2), .load_done(ld2)
`ifdef LOADER_CSUM_EN
      , .csum(cs2)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;
   logic cmp_en = 1'b0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model state: edges since reset release, the bits captured on them, and the values latched at the first.
   int          edge_n = 0;
   logic        stream [4096];
   logic [3:0]  m_feat = '0;
   logic [11:0] m_dp   = '0;

   always @(posedge CLK or negedge RST) begin
      if (!RST) edge_n <= 0;
      else begin
         if (edge_n == 0) begin
            m_feat <= feat;
            m_dp   <= data_points;
         end
         if (edge_n < 4096) stream[edge_n] <= S;
         edge_n <= edge_n + 1;
      end
   end

   int wr_cnt1 = 0;
   int wr_cnt2 = 0;
   always @(posedge CLK) begin
      if (we1 === 1'b1) wr_cnt1++;
      if (we2 === 1'b1) wr_cnt2++;
   end

   // Row r of an f+1-word geometry: slot j holds the (f-j)-th word of that row in stream order.
   function automatic logic [255:0] model_row(input int f, input int r);
      logic [255:0] d = '0;
      int rowbits = (f + 1) * 16;
      for (int j = 0; j <= f; j++)
         for (int b = 0; b < 16; b++)
            d[16*j+b] = stream[r*rowbits + (f-j)*16 + b];
      return d;
   endfunction

   task automatic model_check(input int fmax, input logic we, input logic [11:0] wa,
                              input logic [255:0] wd, input logic bz, input logic ld,
                              input string tag);
      int f, rowbits, total, rows_done, n;
      logic [255:0] e_data;
      logic [11:0]  e_addr;
      f         = (int'(m_feat) > fmax) ? fmax : int'(m_feat);
      rowbits   = (f + 1) * 16;
      total     = (int'(m_dp) + 1) * rowbits;
      n         = edge_n;
      rows_done = ((n > total) ? total : n) / rowbits;
      e_addr    = (rows_done == 0) ? 12'd0 : 12'(rows_done - 1);
      e_data    = (rows_done == 0) ? 256'd0 : model_row(f, rows_done - 1);
      check({tag, " busy"},      256'(bz), 256'(n > 0 && n < total));
      check({tag, " load_done"}, 256'(ld), 256'(n > 0 && n >= total));
      check({tag, " wr_en"},     256'(we), 256'(n > 0 && n <= total && (n % rowbits) == 0));
      check({tag, " wr_addr"},   256'(wa), 256'(e_addr));
      check({tag, " wr_data"},   wd,       e_data);
   endtask

   always @(negedge CLK) begin
      if (cmp_en) begin
         model_check(15, we1, wa1, wd1, bz1, ld1, "d15");
         model_check(8,  we2, wa2, {112'b0, wd2}, bz2, ld2, "d8");
      end
   end

   function automatic logic [15:0] word_of(input int row, input int j);
      return 16'(row * 16'h1000 + j * 16'h0101 + 16'h00C3);
   endfunction

   task automatic do_reset();
      RST = 1'b0;
      S   = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b1;
   endtask

   task automatic send_word(input logic [15:0] w);
      for (int b = 0; b < 16; b++) begin
         S = w[b];
         @(negedge CLK);
      end
   endtask

   task automatic send_rows(input int f, input int first, input int last);
      for (int r = first; r <= last; r++)
         for (int j = f; j >= 0; j--)
            send_word(word_of(r, j));
   endtask

   int wc1, wc2;

   initial begin
      RST = 1'b1; S = 1'b0; feat = 4'd1; data_points = 12'd0;
      #1 RST = 1'b0;
      #1;
      check("reset wr_en",     256'(we1), 256'(0));
      check("reset busy",      256'(bz1), 256'(0));
      check("reset load_done", 256'(ld1), 256'(0));
      check("reset wr_data",   wd1,       256'(0));
      cmp_en = 1'b1;

      // T1: one 2-word row
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      send_word(16'hABCD);
      check("t1 not done mid-row", 256'(ld1), 256'(0));
      send_word(16'h1234);
      check("t1 wr_en",     256'(we1), 256'(1));
      check("t1 wr_addr",   256'(wa1), 256'(0));
      check("t1 wr_data",   wd1,       256'h0000_0000_ABCD_1234);
      check("t1 d8 wr_data", {112'b0, wd2}, 256'h0000_0000_ABCD_1234);
      check("t1 load_done", 256'(ld1), 256'(1));
`ifdef LOADER_CSUM_EN
      check("t1 csum", 256'(cs1), 256'(16'hBE01));
`endif
      @(negedge CLK);
      check("t1 strobe ends", 256'(we1), 256'(0));

`ifdef LOADER_CSUM_EN
      // T6: checksum wraps
      feat = 4'd1; data_points = 12'd0;
      do_reset();
      send_word(16'hFFFF);
      send_word(16'h0002);
      check("t6 csum",      256'(cs1), 256'(16'h0001));
      check("t6 load_done", 256'(ld1), 256'(1));
`endif

      // T2: 12-word rows, 7 rows (the 8-slot instance clamps to 9-word rows)
      feat = 4'd11; data_points = 12'd6;
      do_reset();
      wc1 = wr_cnt1; wc2 = wr_cnt2;
      send_rows(11, 0, 6);
      check("t2 load_done",  256'(ld1), 256'(1));
      check("t2 last addr",  256'(wa1), 256'(6));
      check("t2 slot11",     256'(wd1[191:176]), 256'(word_of(6, 11)));
      check("t2 slot0",      256'(wd1[15:0]),    256'(word_of(6, 0)));
      check("t2 upper zero", 256'(wd1[255:192]), 256'(0));
      check("t2 d8 slot8",   256'(wd2[143:128]), 256'(word_of(4, 5)));
      check("t2 d8 slot0",   256'(wd2[15:0]),    256'(word_of(5, 9)));
      @(negedge CLK);
      check("t2 write count",    256'(wr_cnt1 - wc1), 256'(7));
      check("t2 d8 write count", 256'(wr_cnt2 - wc2), 256'(7));

      // T3: full-width rows; the 8-slot instance clamps feat=15
      feat = 4'hF; data_points = 12'd2;
      do_reset();
      send_rows(15, 0, 2);
      check("t3 slot15",   256'(wd1[255:240]), 256'(word_of(2, 15)));
      check("t3 slot0",    256'(wd1[15:0]),    256'(word_of(2, 0)));
      check("t3 addr",     256'(wa1), 256'(2));
      check("t3 d8 slot8", 256'(wd2[143:128]), 256'(word_of(1, 13)));
      check("t3 d8 slot0", 256'(wd2[15:0]),    256'(word_of(1, 5)));

      // T4: reset in the middle of row 3 of 5
      feat = 4'd2; data_points = 12'd4;
      do_reset();
      send_rows(2, 0, 2);
      send_word(word_of(3, 2));
      for (int b = 0; b < 4; b++) begin
         S = b[0];
         @(negedge CLK);
      end
      check("t4 busy before reset", 256'(bz1), 256'(1));
      check("t4 addr before reset", 256'(wa1), 256'(2));
      #3 RST = 1'b0;
      #1;
      check("t4 async wr_en",   256'(we1), 256'(0));
      check("t4 async wr_addr", 256'(wa1), 256'(0));
      check("t4 async wr_data", wd1,       256'(0));
      check("t4 async busy",    256'(bz1), 256'(0));
      do_reset();
      wc1 = wr_cnt1;
      send_rows(2, 0, 0);
      check("t4 reload first strobe", 256'(we1), 256'(1));
      check("t4 reload first addr",   256'(wa1), 256'(0));
      send_rows(2, 1, 4);
      @(negedge CLK);
      check("t4 reload write count", 256'(wr_cnt1 - wc1), 256'(5));
      check("t4 load_done",          256'(ld1), 256'(1));

      // T5: inputs change mid-load, S toggles after completion
      feat = 4'd3; data_points = 12'd1;
      do_reset();
      wc1 = wr_cnt1;
      send_rows(3, 0, 0);
      feat = 4'd7; data_points = 12'd9;
      send_rows(3, 1, 1);
      check("t5 load_done",  256'(ld1), 256'(1));
      check("t5 slot3",      256'(wd1[63:48]),  256'(word_of(1, 3)));
      check("t5 upper zero", 256'(wd1[255:64]), 256'(0));
      for (int i = 0; i < 100; i++) begin
         S = i[0];
         @(negedge CLK);
      end
      check("t5 no extra writes", 256'(wr_cnt1 - wc1), 256'(2));
      check("t5 done sticky",     256'(ld1), 256'(1));
      check("t5 busy low",        256'(bz1), 256'(0));

      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
